mul_sequencer: RTL
==================

# mul_sequencer

Multi-cycle unsigned shift-and-add multiplier. It acts as the initiator on the ALU operand/result interface, driving `a`/`b`/`cin` into an external `alu` instance and consuming its registered `result`/`cout`. Accepts two DATA_BITS operands on a start pulse and returns a 2·DATA_BITS product with a one-cycle `done` pulse. It sits beside the datapath ALU and shares that ALU's one-cycle registered latency.

## Interface
- DATA_BITS, 8, operand width; must match the attached ALU.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- multiplicand  in  DATA_BITS  captured on accepted start.
- multiplier  in  DATA_BITS  captured on accepted start.
- busy  out  1  high in CHECK and WAIT.
- done  out  1  one-cycle pulse; product valid.
- product  out  2·DATA_BITS  result; holds until the next completion.
- product_zero  out  1  registered with product; product == 0.
- alu_a  out  DATA_BITS  to ALU `a`; continuously = hi register.
- alu_b  out  DATA_BITS  to ALU `b`; continuously = mcand register.
- alu_cin  out  1  tied 0 (add only).
- alu_result  in  DATA_BITS  from ALU, valid the cycle after operands were presented.
- alu_cout  in  1  from ALU, same timing as alu_result.

## Operation
- Registers: mcand[DATA_BITS], hi[DATA_BITS], lo[DATA_BITS], cnt[$clog2(DATA_BITS+1)], state, product, product_zero.
- IDLE:
  - On start: mcand ← multiplicand, hi ← 0, lo ← multiplier, cnt ← 0.
  - Go to CHECK.
- CHECK:
  - If lo[0] = 1, go to WAIT. The ALU samples hi + mcand at this edge.
  - If lo[0] = 0: {hi, lo} ← {0, hi, lo} >> 1, cnt++.
  - If cnt reaches DATA_BITS, go to DONE; otherwise stay in CHECK.
- WAIT:
  - {hi, lo} ← {alu_cout, alu_result, lo} >> 1, cnt++.
  - If cnt reaches DATA_BITS, go to DONE; otherwise go to CHECK.
  - hi and mcand are unchanged since CHECK, so the ALU output corresponds to the current iteration.
- Transition into DONE: product ← {hi, lo}, product_zero ← ({hi, lo} == 0).
- DONE:
  - done = 1 for exactly one cycle.
  - A start sampled in DONE is accepted as in IDLE (back-to-back operation). Otherwise go to IDLE.
- start in CHECK/WAIT is ignored. It is not queued and has no effect on the operation in flight.
- Arithmetic is unsigned. A DATA_BITS+1 carry from alu_cout is shifted into hi[DATA_BITS-1], so no overflow is possible.
- alu_zero is not consumed.

## Timing
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - product = 0, product_zero = 1
  - hi = lo = mcand = cnt = 0
  - alu_a = alu_b = 0, alu_cin = 0
- Cycle numbering:
  - Start is accepted in cycle 0.
  - Iterations occupy cycles 1 .. DATA_BITS+k, where k = popcount(multiplier).
  - done is high in cycle DATA_BITS+1+k.
  - For DATA_BITS = 8: 9 to 17 cycles.
- busy rises in cycle 1 and falls in the DONE cycle.
- product/product_zero change only on the edge entering DONE. They keep their value through subsequent operations until the next DONE.
- Reset mid-operation (any state):
  - Next cycle all registers are at reset values.
  - No done pulse for the aborted operation.
  - product is cleared to 0.

## Structure
- Shared package `mul_seq_pkg`: state enum typedef `mul_state_t {IDLE, CHECK, WAIT, DONE}`.
- Single module with no sub-modules. The ALU is instantiated by the parent and by the bench, not inside mul_sequencer.
- Product width constant 2·DATA_BITS is derived locally.

## Test plan
- 0x0D × 0x0B (k = 3), start in cycle 0:
  - done in cycle 12 only.
  - product = 0x008F, product_zero = 0.
  - busy high in cycles 1–11.
- 0xFF × 0xFF (k = 8):
  - done in cycle 17.
  - product = 0xFE01; carry path exercised on every add.
- 0x37 × 0x00 (k = 0):
  - done in cycle 9.
  - product = 0x0000, product_zero = 1.
  - ALU result never consumed.
- start with 0x02 × 0x03 held high through the whole 0x0D × 0x0B run:
  - First result 0x008F in cycle 12.
  - Second operation accepted in the DONE cycle; 0x0006 done in cycle 12+8+2+1 = 23.
- Reset pulsed in cycle 5 of a 0xFF × 0xFF run:
  - From cycle 6: busy = 0, product = 0, product_zero = 1.
  - No done pulse.
  - A following 0x03 × 0x05 returns 0x000F.
- start pulsed in cycles 3 and 7 during 0x0D × 0x0B: ignored, result and timing identical to the first scenario.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types for the shift-and-add multiplier sequencer.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Registered adder used beside the datapath; the multiplier drives it as an initiator.
module alu #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  input  logic                 cin,
  output logic [DATA_BITS-1:0] result,
  output logic                 cout,
  output logic                 zero
);

  logic [DATA_BITS:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{DATA_BITS{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b1;
    end else begin
      result <= sum[DATA_BITS-1:0];
      cout   <= sum[DATA_BITS];
      zero   <= (sum[DATA_BITS-1:0] == '0);
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned shift-and-add multiplier that borrows an external registered ALU
// for its additions; one iteration per multiplier bit, plus a wait cycle per set bit.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_BITS-1:0]   multiplicand,
  input  logic [DATA_BITS-1:0]   multiplier,
  output logic                   busy,
  output logic                   done,
  output logic [2*DATA_BITS-1:0] product,
  output logic                   product_zero,
  output logic [DATA_BITS-1:0]   alu_a,
  output logic [DATA_BITS-1:0]   alu_b,
  output logic                   alu_cin,
  input  logic [DATA_BITS-1:0]   alu_result,
  input  logic                   alu_cout
);

  localparam int unsigned ProdBits = 2 * DATA_BITS;
  localparam int unsigned CntBits  = $clog2(DATA_BITS + 1);
  localparam logic [CntBits-1:0] CntLast = CntBits'(DATA_BITS);

  mul_state_t            state_q, state_d;
  logic [DATA_BITS-1:0]  mcand_q, mcand_d;
  logic [DATA_BITS-1:0]  hi_q, hi_d;
  logic [DATA_BITS-1:0]  lo_q, lo_d;
  logic [CntBits-1:0]    cnt_q, cnt_d;
  logic [ProdBits-1:0]   product_q, product_d;
  logic                  product_zero_q, product_zero_d;
  logic [CntBits-1:0]    cnt_inc;
  logic                  finish;

  assign cnt_inc = cnt_q + CntBits'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      mcand_q        <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      cnt_q          <= '0;
      product_q      <= '0;
      product_zero_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      mcand_q        <= mcand_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      cnt_q          <= cnt_d;
      product_q      <= product_d;
      product_zero_q <= product_zero_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mcand_d        = mcand_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    cnt_d          = cnt_q;
    product_d      = product_q;
    product_zero_d = product_zero_q;
    finish         = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mcand_d = multiplicand;
          hi_d    = '0;
          lo_d    = multiplier;
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // A set bit leaves hi/mcand untouched so the ALU result is valid in WAIT.
        if (lo_q[0]) begin
          state_d = WAIT;
        end else begin
          hi_d    = {1'b0, hi_q[DATA_BITS-1:1]};
          lo_d    = {hi_q[0], lo_q[DATA_BITS-1:1]};
          cnt_d   = cnt_inc;
          finish  = (cnt_inc == CntLast);
          state_d = finish ? DONE : CHECK;
        end
      end
      WAIT: begin
        hi_d    = {alu_cout, alu_result[DATA_BITS-1:1]};
        lo_d    = {alu_result[0], lo_q[DATA_BITS-1:1]};
        cnt_d   = cnt_inc;
        finish  = (cnt_inc == CntLast);
        state_d = finish ? DONE : CHECK;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      product_d      = {hi_d, lo_d};
      product_zero_d = ({hi_d, lo_d} == '0);
    end
  end

  assign busy         = (state_q == CHECK) || (state_q == WAIT);
  assign done         = (state_q == DONE);
  assign product      = product_q;
  assign product_zero = product_zero_q;
  assign alu_a        = hi_q;
  assign alu_b        = mcand_q;
  assign alu_cin      = 1'b0;

endmodule
